// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between a core memory stage and the data memory LSU.
// master = core side, slave = memory side.
interface data_mem_lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [AW-1:0]         req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-addressable RV32 data memory: SB/SH/SW stores with lane enables, LB/LH/LW/LBU/LHU
// loads with extension, misalignment/illegal-code faults, single-entry response register.
module data_mem_lsu #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_lsu_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS) + 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_fault;

  logic                  w_accept;
  logic                  w_fault;
  logic                  w_wr_en;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata_rep;
  logic [AW-3:0]         w_idx;
  logic [1:0]            w_lane;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [7:0]            w_rd_byte;
  logic [15:0]           w_rd_half;
  logic [DATA_WIDTH-1:0] w_load_data;

  assign w_idx          = bus.req_addr[AW-1:2];
  assign w_lane         = bus.req_addr[1:0];
  assign bus.req_ready  = !r_rsp_valid || bus.rsp_ready;
  assign w_accept       = bus.req_valid && bus.req_ready;
  assign w_wr_en        = rst_n && w_accept && bus.req_we && !w_fault;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_fault     = 1'b0;
    w_be        = 4'b0000;
    w_wdata_rep = bus.req_wdata;
    case (bus.req_funct3)
      F3_B: begin
        w_be        = 4'b0001 << w_lane;
        w_wdata_rep = {4{bus.req_wdata[7:0]}};
      end
      F3_H: begin
        w_fault     = w_lane[0];
        w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{bus.req_wdata[15:0]}};
      end
      F3_W: begin
        w_fault = (w_lane != 2'b00);
        w_be    = 4'b1111;
      end
      F3_BU:   w_fault = bus.req_we;
      F3_HU:   w_fault = bus.req_we || w_lane[0];
      default: w_fault = 1'b1;
    endcase
  end

  // Load path reads the word as it stands at the accepting edge.
  assign w_rd_word = r_mem[w_idx];
  assign w_rd_half = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  always_comb begin
    w_rd_byte = w_rd_word[7:0];
    case (w_lane)
      2'd1:    w_rd_byte = w_rd_word[15:8];
      2'd2:    w_rd_byte = w_rd_word[23:16];
      2'd3:    w_rd_byte = w_rd_word[31:24];
      default: w_rd_byte = w_rd_word[7:0];
    endcase
  end

  always_comb begin
    w_load_data = '0;
    case (bus.req_funct3)
      F3_B:    w_load_data = {{24{w_rd_byte[7]}}, w_rd_byte};
      F3_H:    w_load_data = {{16{w_rd_half[15]}}, w_rd_half};
      F3_W:    w_load_data = w_rd_word;
      F3_BU:   w_load_data = {24'h0, w_rd_byte};
      F3_HU:   w_load_data = {16'h0, w_rd_half};
      default: w_load_data = '0;
    endcase
  end

  // NOTE: the array has no reset; contents survive rst_n, and writes are gated by rst_n instead.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata_rep[b*8 +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_fault <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= (bus.req_we || w_fault) ? '0 : w_load_data;
      r_rsp_fault <= w_fault;
    end else if (bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_fault = r_rsp_fault;
endmodule
